// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg: shared RV32I scalar types (word_t, regidx_t)
package rv32i_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regidx_t;
endpackage

// File: rtl/sparce_pkg.sv
// sparce_pkg: SASA entry struct, skip FSM states, config word offsets and redirect-target helper
package sparce_pkg;
  import rv32i_types_pkg::*;
  typedef struct packed {
    logic        valid;
    logic [29:0] trigger;
    regidx_t     rs1;
    regidx_t     rs2;
    logic        use_rs2;
    logic [15:0] skip_len;
  } sasa_entry_t;
  typedef enum logic [1:0] {IDLE, SKIP, HOLD} sasa_state_t;
  localparam word_t SASA_W0_OFF = 32'h0;
  localparam word_t SASA_W1_OFF = 32'h4;
  function automatic word_t skip_target(logic [29:0] trig, logic [15:0] len);
    return {trig, 2'b00} + {14'h0, len, 2'b00} + 32'd4;
  endfunction
endpackage

// File: rtl/sparce_sasa_ctrl_if.sv
// sparce_sasa_ctrl_if: fetch pc, writeback, SASA config bus (master drives) and skip/target/sparse outputs (slave drives)
interface sparce_sasa_ctrl_if;
  import rv32i_types_pkg::*;
  word_t   pc;
  logic    wb_en;
  regidx_t wb_rd;
  word_t   wb_data;
  logic    sasa_wen;
  word_t   sasa_addr;
  word_t   sasa_data;
  logic    skipping;
  word_t   sparce_target;
  word_t   sparse_vec;
  modport master (
    output pc, wb_en, wb_rd, wb_data, sasa_wen, sasa_addr, sasa_data,
    input  skipping, sparce_target, sparse_vec
  );
  modport slave (
    input  pc, wb_en, wb_rd, wb_data, sasa_wen, sasa_addr, sasa_data,
    output skipping, sparce_target, sparse_vec
  );
endinterface

// File: rtl/sparce_sasa_table.sv
// sparce_sasa_table: skip table with round-robin allocation; ports clk/rst_n, w0/w1 config strobes + wdata, pc_word/sparse lookup in, hit/hit_len out
module sparce_sasa_table
  import rv32i_types_pkg::*, sparce_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w0,
  input  logic        w1,
  input  word_t       wdata,
  input  logic [29:0] pc_word,
  input  word_t       sparse,
  output logic        hit,
  output logic [15:0] hit_len
);
  localparam int VW = $clog2(ENTRIES);
  sasa_entry_t    tbl [ENTRIES];
  sasa_entry_t    new_e;
  logic [VW-1:0]  victim;
  logic [VW-1:0]  match_idx;
  logic           match_any;
  logic [29:0]    pend;
  assign new_e = '{valid: 1'b1, trigger: pend, rs1: wdata[4:0], rs2: wdata[9:5],
                   use_rs2: wdata[10], skip_len: wdata[26:11]};
  always_comb begin
    hit = 1'b0;
    hit_len = '0;
    match_any = 1'b0;
    match_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tbl[i].valid && tbl[i].trigger == pc_word && sparse[tbl[i].rs1] &&
          (!tbl[i].use_rs2 || sparse[tbl[i].rs2])) begin
        hit = 1'b1;
        hit_len = tbl[i].skip_len;
      end
      if (tbl[i].valid && tbl[i].trigger == pend) begin
        match_any = 1'b1;
        match_idx = VW'(i);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
      victim <= '0;
      pend <= '0;
    end else begin
      if (w0) pend <= wdata[31:2];
      if (w1 && new_e.skip_len == '0) begin
        if (match_any) tbl[match_idx].valid <= 1'b0;
      end else if (w1) begin
        tbl[match_any ? match_idx : victim] <= new_e;
        if (!match_any) victim <= victim + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sparce_sasa_ctrl.sv
// sparce_sasa_ctrl: register-sparsity tracker and skip FSM; ports CLK, nRST, bus (slave: pc/wb/config in, skipping/sparce_target/sparse_vec out)
module sparce_sasa_ctrl
  import rv32i_types_pkg::*, sparce_pkg::*;
#(
  parameter int    SASA_ENTRIES = 4,
  parameter word_t SASA_BASE    = 32'h0000_1000
) (
  input logic               CLK,
  input logic               nRST,
  sparce_sasa_ctrl_if.slave bus
);
  sasa_state_t state, state_n;
  word_t       sparse_q, sparse_eff, target_q;
  logic [29:0] hold_pc;
  logic [15:0] hit_len;
  logic        hit, w0, w1, unused_pc;
  assign unused_pc = &{1'b0, bus.pc[1:0]};
  assign w0 = bus.sasa_wen && bus.sasa_addr == SASA_BASE + SASA_W0_OFF;
  assign w1 = bus.sasa_wen && bus.sasa_addr == SASA_BASE + SASA_W1_OFF;
  // same-cycle writeback governs the lookup
  always_comb begin
    sparse_eff = sparse_q;
    if (bus.wb_en && bus.wb_rd != '0) sparse_eff[bus.wb_rd] = (bus.wb_data == '0);
  end
  sparce_sasa_table #(.ENTRIES(SASA_ENTRIES)) u_table (
    .clk     (CLK),
    .rst_n   (nRST),
    .w0      (w0),
    .w1      (w1),
    .wdata   (bus.sasa_data),
    .pc_word (bus.pc[31:2]),
    .sparse  (sparse_eff),
    .hit     (hit),
    .hit_len (hit_len)
  );
  always_comb begin
    state_n = state == IDLE ? (hit ? SKIP : IDLE) :
              state == SKIP ? HOLD :
              (state == HOLD && bus.pc[31:2] == hold_pc) ? HOLD : IDLE;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      target_q <= '0;
      hold_pc <= '0;
      sparse_q <= 32'h1;
    end else begin
      state <= state_n;
      sparse_q <= sparse_eff;
      if (state == IDLE && hit) begin
        target_q <= skip_target(bus.pc[31:2], hit_len);
        hold_pc <= bus.pc[31:2];
      end
    end
  end
  assign bus.skipping = state == SKIP;
  assign bus.sparce_target = target_q;
  assign bus.sparse_vec = sparse_q;
endmodule

// File: tb/tb_sparce_sasa_ctrl.sv
// tb_sparce_sasa_ctrl: vector table, corner sequences and random stimulus against a behavioural model
module tb_sparce_sasa_ctrl;
  import rv32i_types_pkg::*;
  localparam int    N    = 4;
  localparam word_t BASE = 32'h0000_1000;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  sparce_sasa_ctrl_if bus();
  sparce_sasa_ctrl #(.SASA_ENTRIES(N), .SASA_BASE(BASE)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));
  always #5 CLK = ~CLK;
  int tests = 0;
  int fails = 0;
  word_t       m_sparse, m_target;
  logic        m_skip, m_hold;
  logic [29:0] m_hold_trig, m_pend;
  logic        m_v [N];
  logic [29:0] m_t [N];
  logic [4:0]  m_r1 [N], m_r2 [N];
  logic        m_u [N];
  logic [15:0] m_l [N];
  int          m_vict;
  typedef struct {
    logic wb_en; logic [4:0] rd; word_t wdata;
    logic wen; word_t addr; word_t data; word_t pc;
    logic exp_skip; word_t exp_tgt;
  } vec_t;
  vec_t vt [18];
  task automatic check(input string name, input word_t act, input word_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_sparse = 32'h1; m_target = '0; m_skip = 0; m_hold = 0;
    m_hold_trig = '0; m_pend = '0; m_vict = 0;
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_t[i] = '0; m_r1[i] = '0; m_r2[i] = '0; m_u[i] = 0; m_l[i] = '0;
    end
  endtask
  task automatic model_step();
    word_t eff;
    int h, mt;
    logic [29:0] pcw;
    eff = m_sparse;
    if (bus.wb_en && bus.wb_rd != 0) eff[bus.wb_rd] = (bus.wb_data == 0);
    pcw = bus.pc[31:2];
    h = -1;
    for (int i = 0; i < N; i++)
      if (h < 0 && m_v[i] && m_t[i] == pcw && eff[m_r1[i]] && (!m_u[i] || eff[m_r2[i]])) h = i;
    if (m_skip) begin
      m_skip = 0; m_hold = 1;
    end else if (m_hold) begin
      m_hold = (pcw == m_hold_trig);
    end else if (h >= 0) begin
      m_skip = 1;
      m_hold_trig = m_t[h];
      m_target = {m_t[h], 2'b00} + 32'd4 * (32'(m_l[h]) + 32'd1);
    end
    if (bus.sasa_wen && bus.sasa_addr == BASE) m_pend = bus.sasa_data[31:2];
    else if (bus.sasa_wen && bus.sasa_addr == BASE + 32'd4) begin
      mt = -1;
      for (int i = 0; i < N; i++) if (mt < 0 && m_v[i] && m_t[i] == m_pend) mt = i;
      if (bus.sasa_data[26:11] == 0) begin
        if (mt >= 0) m_v[mt] = 0;
      end else begin
        if (mt < 0) begin mt = m_vict; m_vict = (m_vict + 1) % N; end
        m_v[mt] = 1; m_t[mt] = m_pend; m_r1[mt] = bus.sasa_data[4:0];
        m_r2[mt] = bus.sasa_data[9:5]; m_u[mt] = bus.sasa_data[10]; m_l[mt] = bus.sasa_data[26:11];
      end
    end
    m_sparse = eff;
  endtask
  task automatic cyc();
    model_step();
    @(posedge CLK); #1;
    check("model_skipping", bus.skipping, m_skip);
    check("model_target", bus.sparce_target, m_target);
    check("model_sparse_vec", bus.sparse_vec, m_sparse);
  endtask
  task automatic idle();
    bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.sasa_wen = 0; bus.sasa_addr = '0; bus.sasa_data = '0;
  endtask
  task automatic reset_dut();
    idle(); bus.pc = '0;
    nRST = 0;
    model_reset();
    @(posedge CLK); #1;
    check("reset_skipping", bus.skipping, 0);
    check("reset_target", bus.sparce_target, 0);
    check("reset_sparse_vec", bus.sparse_vec, 32'h1);
    nRST = 1;
  endtask
  task automatic cfg(input word_t trig, input word_t d);
    bus.sasa_wen = 1; bus.sasa_addr = BASE; bus.sasa_data = trig; cyc();
    bus.sasa_addr = BASE + 32'd4; bus.sasa_data = d; cyc();
    idle();
  endtask
  task automatic wb(input logic [4:0] rd, input word_t val);
    bus.wb_en = 1; bus.wb_rd = rd; bus.wb_data = val; cyc();
    idle();
  endtask
  task automatic probe(input string name, input word_t pcv, input logic exp, input word_t tgt);
    bus.pc = pcv; cyc();
    check(name, bus.skipping, exp);
    if (exp) check({name, "_target"}, bus.sparce_target, tgt);
    bus.pc = '0; cyc(); cyc();
  endtask
  initial begin
    vt[0]  = '{0, 0, 0, 1, BASE,         32'h200,  0,       0, 0};
    vt[1]  = '{0, 0, 0, 1, BASE + 32'd4, 32'h1805, 0,       0, 0};
    vt[2]  = '{1, 5, 0, 0, 0,            0,        0,       0, 0};
    vt[3]  = '{0, 0, 0, 0, 0,            0,        32'h200, 1, 32'h210};
    vt[4]  = '{0, 0, 0, 0, 0,            0,        32'h200, 0, 32'h210};
    vt[5]  = '{0, 0, 0, 0, 0,            0,        32'h200, 0, 32'h210};
    vt[6]  = '{0, 0, 0, 0, 0,            0,        32'h200, 0, 32'h210};
    vt[7]  = '{0, 0, 0, 0, 0,            0,        32'h200, 0, 32'h210};
    vt[8]  = '{0, 0, 0, 0, 0,            0,        32'h210, 0, 32'h210};
    vt[9]  = '{0, 0, 0, 0, 0,            0,        32'h200, 1, 32'h210};
    vt[10] = '{0, 0, 0, 0, 0,            0,        32'h204, 0, 32'h210};
    vt[11] = '{0, 0, 0, 0, 0,            0,        32'h204, 0, 32'h210};
    vt[12] = '{1, 5, 1, 0, 0,            0,        32'h200, 0, 32'h210};
    vt[13] = '{0, 0, 0, 0, 0,            0,        32'h200, 0, 32'h210};
    vt[14] = '{0, 0, 0, 1, BASE + 32'd8, 32'h300,  0,       0, 32'h210};
    vt[15] = '{0, 0, 0, 1, BASE + 32'd4, 32'h1800, 0,       0, 32'h210};
    vt[16] = '{0, 0, 0, 0, 0,            0,        32'h200, 1, 32'h210};
    vt[17] = '{0, 0, 0, 0, 0,            0,        0,       0, 32'h210};
    reset_dut();
    for (int i = 0; i < 18; i++) begin
      bus.wb_en = vt[i].wb_en; bus.wb_rd = vt[i].rd; bus.wb_data = vt[i].wdata;
      bus.sasa_wen = vt[i].wen; bus.sasa_addr = vt[i].addr; bus.sasa_data = vt[i].data;
      bus.pc = vt[i].pc;
      cyc();
      check($sformatf("vec%0d_skipping", i), bus.skipping, vt[i].exp_skip);
      check($sformatf("vec%0d_target", i), bus.sparce_target, vt[i].exp_tgt);
    end
    idle();
    reset_dut();
    for (int k = 0; k < 5; k++) cfg(32'h400 + 32'(k) * 32'h100, 32'h0800);
    for (int k = 0; k < 5; k++)
      probe($sformatf("evict_trig%0d", k), 32'h400 + 32'(k) * 32'h100, k != 0, 32'h408 + 32'(k) * 32'h100);
    cfg(32'h900, 32'h14E0);
    wb(5'd7, 32'h5);
    probe("rs2_nonzero", 32'h900, 0, 0);
    wb(5'd7, 32'h0);
    probe("rs2_zero", 32'h900, 1, 32'h90C);
    cfg(32'h900, 32'h04E0);
    probe("invalidated", 32'h900, 0, 0);
    reset_dut();
    cfg(32'h200, 32'h1800);
    bus.pc = 32'h200; cyc();
    check("pre_reset_skipping", bus.skipping, 1);
    nRST = 0; #1;
    check("async_drop_skipping", bus.skipping, 0);
    check("async_target", bus.sparce_target, 0);
    check("async_sparse_vec", bus.sparse_vec, 32'h1);
    model_reset();
    @(posedge CLK); #1;
    nRST = 1;
    probe("old_trigger_after_reset", 32'h200, 0, 0);
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.wb_en = 1'($urandom_range(0, 1));
      bus.wb_rd = 5'($urandom_range(0, 3));
      bus.wb_data = $urandom_range(0, 1) ? 32'h0 : 32'($urandom);
      bus.sasa_wen = r < 4;
      bus.sasa_addr = r == 0 ? BASE : (r < 3) ? BASE + 32'd4 : BASE + 32'd8;
      bus.sasa_data = r == 0 ? 32'h200 + 32'd4 * 32'($urandom_range(0, 5)) :
                      {5'($urandom), 16'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) bus.pc = 32'h200 + 32'd4 * 32'($urandom_range(0, 5));
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
